// File: rtl/game_pkg.sv
// Shared game-phase encoding and boss FSM state type.
package game_pkg;

    localparam logic [1:0] GAME_FIGHT = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIGHT = 2'd1,
        DEAD  = 2'd2
    } boss_state_t;

endpackage

// File: rtl/hit_edge_det.sv
// Rising-edge detector; history presets to 1 so a level held through reset is not a hit.
module hit_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic hist;

    always_ff @(posedge clk) begin
        if (!rst) hist <= 1'b1;
        else      hist <= din;
    end

    assign rise = din & ~hist;

endmodule

// File: rtl/boss_damage_ctrl.sv
// Boss HP / defeat controller fed by weapon-stage hit levels.
// Optional hit_flash counter built only when BOSS_DMG_FLASH_EN is defined.
//
//  state | meaning
//  IDLE  | outside a fight, HP parked at max, hits ignored
//  FIGHT | boss alive, hits reduce HP
//  DEAD  | HP reached 0, waiting for the fight phase to end
module boss_damage_ctrl
    import game_pkg::*;
#(
    parameter int HP_W          = 8,
    parameter int BOSS_HP_MAX   = 100,
    parameter int PROJ_DMG      = 2,
    parameter int MELEE_DMG     = 5,
    parameter int MELEE_IFRAMES = 8
`ifdef BOSS_DMG_FLASH_EN
    ,parameter int FLASH_FRAMES = 4
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_tick,
    input  logic [1:0]      game_active,
    input  logic            projectile_hit,
    input  logic            melee_hit,
    output logic            boss_alive,
    output logic [HP_W-1:0] boss_hp,
    output logic            boss_defeated,
    output logic            hit_flash
);

    localparam int IF_W = $clog2(MELEE_IFRAMES + 1);
    localparam logic [HP_W-1:0] HP_LOAD  = HP_W'(BOSS_HP_MAX);
    localparam logic [HP_W:0]   P_DMG    = (HP_W + 1)'(PROJ_DMG);
    localparam logic [HP_W:0]   M_DMG    = (HP_W + 1)'(MELEE_DMG);
    localparam logic [IF_W-1:0] IF_LOAD  = IF_W'(MELEE_IFRAMES);

    boss_state_t     state, state_nxt;
    logic [HP_W-1:0] hp_q, hp_nxt;
    logic [IF_W-1:0] ifr_q, ifr_nxt;
    logic            defeated_q, defeated_nxt;
    logic            proj_rise, melee_rise, melee_ok, in_fight;
    logic [HP_W:0]   dmg, hp_sub;

    hit_edge_det u_proj_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (projectile_hit),
        .rise (proj_rise)
    );

    hit_edge_det u_melee_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (melee_hit),
        .rise (melee_rise)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            hp_q       <= HP_LOAD;
            ifr_q      <= '0;
            defeated_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            hp_q       <= hp_nxt;
            ifr_q      <= ifr_nxt;
            defeated_q <= defeated_nxt;
        end
    end

    // Damage is summed one bit wider than HP so the saturating compare never wraps.
    always_comb begin
        in_fight = (game_active == GAME_FIGHT);
        melee_ok = melee_rise && (ifr_q == '0);
        dmg      = (proj_rise ? P_DMG : '0) + (melee_ok ? M_DMG : '0);
        hp_sub   = ({1'b0, hp_q} > dmg) ? ({1'b0, hp_q} - dmg) : '0;
    end

    always_comb begin
        state_nxt    = state;
        hp_nxt       = hp_q;
        ifr_nxt      = ifr_q;
        defeated_nxt = 1'b0;
        case (state)
            IDLE: begin
                hp_nxt  = HP_LOAD;
                ifr_nxt = '0;
                if (in_fight) state_nxt = FIGHT;
            end
            FIGHT: begin
                if (!in_fight) begin
                    state_nxt = IDLE;
                    hp_nxt    = HP_LOAD;
                    ifr_nxt   = '0;
                end else begin
                    if (melee_ok)                       ifr_nxt = IF_LOAD;
                    else if (frame_tick && ifr_q != '0) ifr_nxt = ifr_q - 1'b1;
                    if (dmg != '0) begin
                        hp_nxt = hp_sub[HP_W-1:0];
                        if (hp_sub == '0) begin
                            state_nxt    = DEAD;
                            defeated_nxt = 1'b1;
                        end
                    end
                end
            end
            DEAD: begin
                hp_nxt  = '0;
                ifr_nxt = '0;
                if (!in_fight) begin
                    state_nxt = IDLE;
                    hp_nxt    = HP_LOAD;
                end
            end
            default: begin
                state_nxt = IDLE;
                hp_nxt    = HP_LOAD;
                ifr_nxt   = '0;
            end
        endcase
    end

    assign boss_alive    = (state == FIGHT);
    assign boss_hp       = hp_q;
    assign boss_defeated = defeated_q;

`ifdef BOSS_DMG_FLASH_EN
    localparam int FL_W = $clog2(FLASH_FRAMES + 1);
    localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FLASH_FRAMES);

    logic [FL_W-1:0] flash_q, flash_nxt;

    always_ff @(posedge clk) begin
        if (!rst) flash_q <= '0;
        else      flash_q <= flash_nxt;
    end

    // The defeating hit's flash is allowed to run out while DEAD.
    always_comb begin
        flash_nxt = flash_q;
        case (state)
            FIGHT: begin
                if (!in_fight)                        flash_nxt = '0;
                else if (dmg != '0)                   flash_nxt = FL_LOAD;
                else if (frame_tick && flash_q != '0) flash_nxt = flash_q - 1'b1;
            end
            DEAD: begin
                if (!in_fight)                        flash_nxt = '0;
                else if (frame_tick && flash_q != '0) flash_nxt = flash_q - 1'b1;
            end
            default: flash_nxt = '0;
        endcase
    end

    assign hit_flash = (flash_q != '0);
`else
    assign hit_flash = 1'b0;
`endif

endmodule
